// File: rtl/cpa_pkg.sv
// Shared sizing helpers for the pipelined carry-propagate adder: segment width
// and per-segment bit bounds, plus the default WIDTH/STAGES.
package cpa_pkg;

    localparam int CPA_WIDTH_DEF  = 33;
    localparam int CPA_STAGES_DEF = 4;

    function automatic int cpa_seg_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int cpa_seg_lo(input int k, input int width, input int stages);
        return k * cpa_seg_width(width, stages);
    endfunction

    // The last segment is clipped at the operand MSB and may be narrower.
    function automatic int cpa_seg_hi(input int k, input int width, input int stages);
        int h;
        h = (k + 1) * cpa_seg_width(width, stages);
        if (h > width) h = width;
        return h - 1;
    endfunction

endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell used as the ripple element of every segment.
module FullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/cpa_segment.sv
// Combinational W-bit ripple adder: one carry segment of the pipelined CPA.
module cpa_segment #(
    parameter int W = 9
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < W; i++) begin : g_bit
        FullAdder u_fa (
            .a_i  (x_i[i]),
            .b_i  (y_i[i]),
            .ci_i (c[i]),
            .s_o  (sum_o[i]),
            .co_o (c[i+1])
        );
    end

    assign cout_o = c[W];

endmodule

// File: rtl/pipelined_cpa.sv
// Pipelined carry-propagate adder: one ripple segment per stage, operand skew
// and sum deskew registers, valid/ready on both sides. Optional subtract via CPA_SUB_EN.
module pipelined_cpa
    import cpa_pkg::*;
#(
    parameter int WIDTH  = CPA_WIDTH_DEF,
    parameter int STAGES = CPA_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CPA_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = cpa_seg_width(WIDTH, STAGES);

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (STAGES - 1) * CW >= WIDTH) begin : g_bad_cfg
        $error("pipelined_cpa: WIDTH/STAGES leave an empty carry segment");
    end

    logic              advance;
    logic [STAGES:1]   vld_q;
    logic [STAGES:0]   vld_chain;
    logic [WIDTH-1:0]  y_eff;
    logic              cin0;

    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign vld_chain = {vld_q, in_valid};
    assign out_valid = vld_q[STAGES];

    // Subtraction is folded in at the input so sub never has to travel down the pipe.
`ifdef CPA_SUB_EN
    assign y_eff = sub ? ~y : y;
    assign cin0  = sub;
`else
    assign y_eff = y;
    assign cin0  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q <= vld_chain[STAGES-1:0];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = cpa_seg_lo(k, WIDTH, STAGES);
        localparam int HI = cpa_seg_hi(k, WIDTH, STAGES);

        logic [HI-LO:0] seg_x, seg_y, seg_s;
        logic           seg_cin, seg_cout;
        logic [HI:0]    s_q, s_d;
        logic           c_q;

        if (k == 0) begin : g_head
            assign seg_x   = x[HI:LO];
            assign seg_y   = y_eff[HI:LO];
            assign seg_cin = cin0;
            assign s_d     = seg_s;
        end else begin : g_body
            assign seg_x   = g_stg[k-1].g_skew.xs_q[HI:LO];
            assign seg_y   = g_stg[k-1].g_skew.ys_q[HI:LO];
            assign seg_cin = g_stg[k-1].c_q;
            assign s_d     = {seg_s, g_stg[k-1].s_q};
        end

        cpa_segment #(.W(HI - LO + 1)) u_seg (
            .x_i    (seg_x),
            .y_i    (seg_y),
            .cin_i  (seg_cin),
            .sum_o  (seg_s),
            .cout_o (seg_cout)
        );

        // s_q grows by one segment per stage: lower bits are the deskew chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (advance) begin
                s_q <= s_d;
                c_q <= seg_cout;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:HI+1] xs_q, ys_q, xs_d, ys_d;

            if (k == 0) begin : g_src_in
                assign xs_d = x[WIDTH-1:HI+1];
                assign ys_d = y_eff[WIDTH-1:HI+1];
            end else begin : g_src_prev
                assign xs_d = g_stg[k-1].g_skew.xs_q[WIDTH-1:HI+1];
                assign ys_d = g_stg[k-1].g_skew.ys_q[WIDTH-1:HI+1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    xs_q <= '0;
                    ys_q <= '0;
                end else if (advance) begin
                    xs_q <= xs_d;
                    ys_q <= ys_d;
                end
            end
        end
    end

    assign sum  = g_stg[STAGES-1].s_q;
    assign cout = g_stg[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_cpa.sv
// Directed bench for pipelined_cpa (WIDTH=33, STAGES=4): latency, streaming,
// backpressure, mid-flight reset and, when CPA_SUB_EN is defined, subtraction.
module tb_pipelined_cpa;

    localparam int W = 33;
    localparam int S = 4;
    localparam int N = 24;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, cout;
    logic [W-1:0] x, y, sum;
`ifdef CPA_SUB_EN
    logic         sub;
`endif

    int checks   = 0;
    int failures = 0;

    pipelined_cpa #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CPA_SUB_EN
        .sub       (sub),
`endif
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] vx [8];
    logic [W-1:0] vy [8];
    logic [W-1:0] vs [8];
    logic         vc [8];

    initial begin
        logic [W:0]   q[$];
        logic [W:0]   e;
        logic [W-1:0] bx, by, hold_s;
        logic         hold_c, stalled;
        int           sent, got, cyc;

        vx = '{33'h0_0000_0003, 33'h1_0000_0000, 33'h0_FFFF_FFFF, 33'h0_0000_01FF,
               33'h0_07FF_FFFF, 33'h1_2345_6789, 33'h1_FFFF_FFFF, 33'h0_AAAA_AAAA};
        vy = '{33'h0_0000_0004, 33'h1_0000_0000, 33'h0_0000_0001, 33'h0_0000_0001,
               33'h0_0000_0001, 33'h0_1111_1111, 33'h1_FFFF_FFFF, 33'h0_5555_5556};
        vs = '{33'h0_0000_0007, 33'h0_0000_0000, 33'h1_0000_0000, 33'h0_0000_0200,
               33'h0_0800_0000, 33'h1_3456_789A, 33'h1_FFFF_FFFE, 33'h1_0000_0000};
        vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
`ifdef CPA_SUB_EN
        sub = 1'b0;
`endif
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_in_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        // Full-width carry: latency exactly S cycles, valid for one cycle.
        x = 33'h1_FFFF_FFFF; y = 33'h0_0000_0001; in_valid = 1'b1;
        for (int n = 1; n <= S + 1; n++) begin
            step();
            in_valid = 1'b0;
            chk($sformatf("lat_valid_c%0d", n), out_valid, (n == S) ? 1 : 0);
            if (n == S) begin
                chk("lat_sum", sum, 0);
                chk("lat_cout", cout, 1);
            end
        end

        // Back-to-back stream of directed vectors.
        x = vx[0]; y = vy[0]; in_valid = 1'b1;
        for (int n = 1; n < 8 + S; n++) begin
            step();
            if (n >= S) begin
                chk($sformatf("str_valid_%0d", n - S), out_valid, 1);
                chk($sformatf("str_sum_%0d", n - S), sum, vs[n-S]);
                chk($sformatf("str_cout_%0d", n - S), cout, vc[n-S]);
            end
            if (n < 8) begin
                x = vx[n]; y = vy[n];
            end else begin
                in_valid = 1'b0;
            end
        end
        step();
        chk("str_bubble", out_valid, 0);

        // Random backpressure against a queue model of x+y.
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; hold_s = '0; hold_c = 1'b0;
        bx = W'({$urandom(), $urandom()});
        by = W'({$urandom(), $urandom()});
        while (got < N && cyc < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < N) begin
                in_valid = 1'b1; x = bx; y = by;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) chk("bp_in_ready", in_ready, out_ready);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("bp_spurious", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("bp_sum_%0d", got), sum, e[W-1:0]);
                    chk($sformatf("bp_cout_%0d", got), cout, e[W]);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back({1'b0, x} + {1'b0, y});
                sent++;
                bx = W'({$urandom(), $urandom()});
                by = W'({$urandom(), $urandom()});
            end
            stalled = out_valid && !out_ready;
            hold_s = sum; hold_c = cout;
            step();
            if (stalled) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_sum", sum, hold_s);
                chk("bp_hold_cout", cout, hold_c);
            end
            cyc++;
        end
        chk("bp_count", got, N);

        // Drain, then reset with three results in flight.
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < S + 2; n++) step();
        for (int i = 0; i < 3; i++) begin
            x = W'(i + 1); y = W'(i + 100); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_sum", sum, 0);
        chk("mrst_cout", cout, 0);
        step();
        rst_n = 1'b1;
        for (int n = 0; n < S + 2; n++) begin
            step();
            chk("mrst_no_ghost", out_valid, 0);
        end
        x = 33'd5; y = 33'd7; in_valid = 1'b1;
        for (int n = 1; n <= S; n++) begin
            step();
            in_valid = 1'b0;
            chk($sformatf("post_rst_valid_c%0d", n), out_valid, (n == S) ? 1 : 0);
        end
        chk("post_rst_sum", sum, 12);

`ifdef CPA_SUB_EN
        step();
        x = 33'd5; y = 33'd7; sub = 1'b1; in_valid = 1'b1;
        step();
        x = 33'd7; y = 33'd5; sub = 1'b1;
        step();
        in_valid = 1'b0; sub = 1'b0;
        for (int n = 2; n < S; n++) step();
        chk("sub_a_valid", out_valid, 1);
        chk("sub_a_sum", sum, 33'h1_FFFF_FFFE);
        chk("sub_a_cout", cout, 0);
        step();
        chk("sub_b_valid", out_valid, 1);
        chk("sub_b_sum", sum, 2);
        chk("sub_b_cout", cout, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
